// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared BIST types, default taps and count-width helper
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } bist_state_t;

  // Feedback mask for 1+x^2+x^3, the same polynomial the TPG runs on
  localparam logic [2:0] TPG_TAPS = 3'b011;

  // Bits needed to hold a beat count from 0 up to and including n
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/misr_core.sv
// rtl/misr_core.sv - WIDTH-bit multiple-input signature register
module misr_core
  import bist_pkg::*;
#(
  parameter int               WIDTH = 3,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TPG_TAPS)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] sig
);

  logic [WIDTH-1:0] sig_next;

  // Shift toward bit 0 with the tapped parity folded into the top bit
  always_comb begin
    sig_next             = '0;
    sig_next[WIDTH-2:0]  = sig[WIDTH-1:1] ^ d[WIDTH-2:0];
    sig_next[WIDTH-1]    = (^(sig & TAPS)) ^ d[WIDTH-1];
  end

  // Signature state; a clear wins over a compaction in the same cycle
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/bist_misr_analyzer.sv
// rtl/bist_misr_analyzer.sv - BIST response analyzer top; optional X-masking via MISR_XMASK_EN
module bist_misr_analyzer
  import bist_pkg::*;
#(
  parameter int               WIDTH      = 3,
  parameter int               N_PATTERNS = 3,
  parameter logic [WIDTH-1:0] TAPS       = WIDTH'(TPG_TAPS),
  parameter logic [WIDTH-1:0] GOLDEN     = WIDTH'(3'b001)
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic                                Start,
  input  logic                                Valid,
  input  logic [WIDTH-1:0]                    Din,
`ifdef MISR_XMASK_EN
  input  logic [WIDTH-1:0]                    Mask,
`endif
  output logic                                Busy,
  output logic                                Done,
  output logic                                Pass,
  output logic [WIDTH-1:0]                    Signature,
  output logic [cnt_width(N_PATTERNS)-1:0]    Count
);

  localparam int            CW   = cnt_width(N_PATTERNS);
  localparam logic [CW-1:0] LAST = CW'(N_PATTERNS - 1);

  bist_state_t      state, state_next;
  logic             misr_clr;
  logic             misr_en;
  logic             check_now;
  logic [WIDTH-1:0] d;

`ifdef MISR_XMASK_EN
  assign d = Din & ~Mask;
`else
  assign d = Din;
`endif

  // FSM state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and per-cycle control strobes
  always_comb begin
    state_next = state;
    misr_clr   = 1'b0;
    misr_en    = 1'b0;
    check_now  = 1'b0;
    Busy       = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (Start) begin
          misr_clr   = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        Busy = 1'b1;
        if (Valid) begin
          misr_en = 1'b1;
          if (Count == LAST) begin
            state_next = CHECK;
          end
        end
      end
      CHECK: begin
        Busy       = 1'b1;
        check_now  = 1'b1;
        state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Beat counter; cleared on session start, stops at N_PATTERNS via the FSM exit
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Count <= '0;
    end else if (misr_clr) begin
      Count <= '0;
    end else if (misr_en) begin
      Count <= Count + 1'b1;
    end
  end

  // Result flags: cleared on restart, latched when CHECK exits
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Done <= 1'b0;
      Pass <= 1'b0;
    end else if (misr_clr) begin
      Done <= 1'b0;
      Pass <= 1'b0;
    end else if (check_now) begin
      Done <= 1'b1;
      Pass <= (Signature == GOLDEN);
    end
  end

  misr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_misr (
    .CLK (CLK),
    .RST (RST),
    .clr (misr_clr),
    .en  (misr_en),
    .d   (d),
    .sig (Signature)
  );

endmodule

// File: tb/tb_bist_misr_analyzer.sv
// tb/tb_bist_misr_analyzer.sv - directed self-checking bench for bist_misr_analyzer
module tb_bist_misr_analyzer;

  logic       CLK;
  logic       RST;
  logic       Start;
  logic       Valid;
  logic [2:0] Din;
  logic [2:0] Mask;
  logic       Busy;
  logic       Done;
  logic       Pass;
  logic [2:0] Signature;
  logic [1:0] Count;

  int checks = 0;
  int errors = 0;

  bist_misr_analyzer dut (
    .CLK       (CLK),
    .RST       (RST),
    .Start     (Start),
    .Valid     (Valid),
    .Din       (Din),
`ifdef MISR_XMASK_EN
    .Mask      (Mask),
`endif
    .Busy      (Busy),
    .Done      (Done),
    .Pass      (Pass),
    .Signature (Signature),
    .Count     (Count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic beat(input logic [2:0] v);
    Valid = 1'b1;
    Din   = v;
    tick();
    Valid = 1'b0;
    Din   = 3'b000;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic b, input logic dn, input logic p,
                         input logic [2:0] s, input logic [1:0] c);
    chk({tag, "_busy"}, 32'(Busy), 32'(b));
    chk({tag, "_done"}, 32'(Done), 32'(dn));
    chk({tag, "_pass"}, 32'(Pass), 32'(p));
    chk({tag, "_sig"},  32'(Signature), 32'(s));
    chk({tag, "_cnt"},  32'(Count), 32'(c));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b0; Start = 1'b0; Valid = 1'b0; Din = 3'b000; Mask = 3'b000;
    #12;
    chk_all("reset", 1'b0, 1'b0, 1'b0, 3'b000, 2'd0);
    RST = 1'b1;
    tick();
    chk_all("idle", 1'b0, 1'b0, 1'b0, 3'b000, 2'd0);

    // Basic passing session
    pulse_start();
    chk_all("t1_start", 1'b1, 1'b0, 1'b0, 3'b000, 2'd0);
    beat(3'b101); chk_all("t1_b1", 1'b1, 1'b0, 1'b0, 3'b101, 2'd1);
    beat(3'b011); chk_all("t1_b2", 1'b1, 1'b0, 1'b0, 3'b101, 2'd2);
    beat(3'b111); chk_all("t1_b3", 1'b1, 1'b0, 1'b0, 3'b001, 2'd3);
    tick();       chk_all("t1_done", 1'b0, 1'b1, 1'b1, 3'b001, 2'd3);
    beat(3'b010); chk_all("t1_hold", 1'b0, 1'b1, 1'b1, 3'b001, 2'd3);

    // Restart from DONE, failing signature
    pulse_start();
    chk_all("t2_start", 1'b1, 1'b0, 1'b0, 3'b000, 2'd0);
    beat(3'b101);
    beat(3'b011);
    beat(3'b110); chk_all("t2_b3", 1'b1, 1'b0, 1'b0, 3'b000, 2'd3);
    tick();       chk_all("t2_done", 1'b0, 1'b1, 1'b0, 3'b000, 2'd3);

    // Gaps between beats
    pulse_start();
    beat(3'b101);
    tick();       chk_all("t3_gap1", 1'b1, 1'b0, 1'b0, 3'b101, 2'd1);
    beat(3'b011);
    tick();
    tick();       chk_all("t3_gap2", 1'b1, 1'b0, 1'b0, 3'b101, 2'd2);
    beat(3'b111); chk_all("t3_b3", 1'b1, 1'b0, 1'b0, 3'b001, 2'd3);
    tick();       chk_all("t3_done", 1'b0, 1'b1, 1'b1, 3'b001, 2'd3);

    // Start together with Valid: the beat is not taken
    Start = 1'b1; Valid = 1'b1; Din = 3'b111;
    tick();
    Start = 1'b0; Valid = 1'b0; Din = 3'b000;
    chk_all("t4_sv", 1'b1, 1'b0, 1'b0, 3'b000, 2'd0);
    Start = 1'b1;
    beat(3'b101);
    Start = 1'b0;
    chk_all("t4_startrun", 1'b1, 1'b0, 1'b0, 3'b101, 2'd1);
    pulse_start();
    chk_all("t4_startonly", 1'b1, 1'b0, 1'b0, 3'b101, 2'd1);
    beat(3'b011);
    beat(3'b111);
    tick();       chk_all("t4_done", 1'b0, 1'b1, 1'b1, 3'b001, 2'd3);

    // Asynchronous reset mid-session
    pulse_start();
    beat(3'b101);
    beat(3'b011);
    chk_all("t5_pre", 1'b1, 1'b0, 1'b0, 3'b101, 2'd2);
    #2 RST = 1'b0;
    #1 chk_all("t5_async", 1'b0, 1'b0, 1'b0, 3'b000, 2'd0);
    #3 RST = 1'b1;
    Valid = 1'b1; Din = 3'b111;
    tick();
    tick();
    Valid = 1'b0; Din = 3'b000;
    chk_all("t5_idle", 1'b0, 1'b0, 1'b0, 3'b000, 2'd0);

    // Full session after reset recovers a passing result
    pulse_start();
    beat(3'b101);
    beat(3'b011);
    beat(3'b111);
    tick();       chk_all("t6_done", 1'b0, 1'b1, 1'b1, 3'b001, 2'd3);

`ifdef MISR_XMASK_EN
    // Masked compaction: d = 100, 010, 110
    Mask = 3'b001;
    pulse_start();
    beat(3'b101); chk("t7_b1", 32'(Signature), 32'h4);
    beat(3'b011); chk("t7_b2", 32'(Signature), 32'h0);
    beat(3'b111); chk("t7_b3", 32'(Signature), 32'h6);
    tick();       chk_all("t7_done", 1'b0, 1'b1, 1'b0, 3'b110, 2'd3);
    Mask = 3'b000;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
